output_drain_ctrl: RTL and testbench

Sequencer that drains the 16-entry result memory of the 4x4 systolic array once a computation completes. On `start` it walks read addresses 0..15 into the synchronous-read output memory, absorbs the one-cycle read latency, and streams each 33-bit result out over a valid/ready interface tagged with its address. It sits between the output memory and the downstream result consumer (host interface or writeback), sustaining one word per cycle under no backpressure.

---
 rtl/output_drain_ctrl.sv | 128 ++++++++++++
 tb/tb_output_drain_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/output_drain_ctrl.sv
// rtl/output_drain_ctrl.sv - drains the result memory over a valid/ready stream
module output_drain_ctrl #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 33
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_read_addr,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last
);
    localparam logic [ADDR_W:0]   DEPTH_V   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_nxt;

    logic [ADDR_W:0]   issue_cnt;
    logic              inflight;
    logic [ADDR_W-1:0] inflight_addr;
    logic [DATA_W-1:0] fifo_data [2];
    logic [ADDR_W-1:0] fifo_addr [2];
    logic [1:0]        fifo_last;
    logic              rd_ptr;
    logic              wr_ptr;
    logic [1:0]        fifo_count;
    logic              pop;
    logic              push;
    logic              issue;
    logic              last_pop;
    logic              done_nxt;
    logic [2:0]        credit;

    assign busy      = (state == RUN);
    assign out_valid = (fifo_count != 2'd0);
    assign out_data  = fifo_data[rd_ptr];
    assign out_addr  = fifo_addr[rd_ptr];
    assign out_last  = fifo_last[rd_ptr];

    assign pop      = out_valid & out_ready;
    assign push     = inflight;
    assign last_pop = busy & pop & out_last;

    // A read may only be launched if its word is guaranteed a FIFO slot,
    // counting the word leaving this very cycle.
    assign credit = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
    assign issue  = busy && (issue_cnt < DEPTH_V) && (credit < 3'd2);

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                if (last_pop) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_cnt     <= '0;
            mem_read_addr <= '0;
            inflight      <= 1'b0;
            inflight_addr <= '0;
            rd_ptr        <= 1'b0;
            wr_ptr        <= 1'b0;
            fifo_count    <= '0;
            fifo_last     <= '0;
            for (int i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
                fifo_addr[i] <= '0;
            end
        end else if (state == IDLE) begin
            inflight <= 1'b0;
            if (start) begin
                issue_cnt     <= '0;
                mem_read_addr <= '0;
                rd_ptr        <= 1'b0;
                wr_ptr        <= 1'b0;
                fifo_count    <= '0;
            end
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_addr <= mem_read_addr;
                issue_cnt     <= issue_cnt + 1'b1;
                if (mem_read_addr != LAST_ADDR)
                    mem_read_addr <= mem_read_addr + 1'b1;
            end
            if (push) begin
                fifo_data[wr_ptr] <= mem_read_data;
                fifo_addr[wr_ptr] <= inflight_addr;
                fifo_last[wr_ptr] <= (inflight_addr == LAST_ADDR);
                wr_ptr            <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end
endmodule

// File: tb/tb_output_drain_ctrl.sv
// tb/tb_output_drain_ctrl.sv - scoreboard bench for output_drain_ctrl
module tb_output_drain_ctrl;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 33;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] mem_read_addr;
    logic [DATA_W-1:0] mem_read_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              out_last;

    always #5 clk = ~clk;

    output_drain_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .mem_read_addr(mem_read_addr), .mem_read_data(mem_read_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .out_last(out_last)
    );

    logic [DATA_W-1:0] mem [DEPTH];
    always @(posedge clk) mem_read_data <= mem[mem_read_addr];

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
        logic              last;
    } word_t;
    word_t exp_q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int run_start = 0;
    int hs_count = 0;
    int first_hs = -1;
    int last_hs = -1;
    int done_rel = -1;
    int done_count = 0;
    bit done_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc - run_start);
        end
    endtask

    // Scoreboard monitor: every handshake consumes the oldest expected word.
    always @(negedge clk) begin
        word_t w;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (hs_count == 0) first_hs = cyc - run_start;
            last_hs = cyc - run_start;
            hs_count++;
            check("word_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                w = exp_q.pop_front();
                check("out_data", out_data, w.data);
                check("out_addr", out_addr, w.addr);
                check("out_last", out_last, w.last);
            end
        end
        if (done === 1'b1) begin
            done_rel = cyc - run_start;
            done_count++;
            check("done_one_cycle", done_prev, 0);
            check("busy_at_done", busy, 0);
        end
        done_prev = (done === 1'b1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic ready_fn(input int mode, input int rel);
        case (mode)
            1:       return !(rel >= 5 && rel <= 9);
            2:       return (rel % 2) == 0;
            3:       return 1'($urandom_range(0, 1));
            default: return 1'b1;
        endcase
    endfunction

    task automatic load_expected();
        word_t w;
        for (int a = 0; a < DEPTH; a++) begin
            w.data = mem[a];
            w.addr = ADDR_W'(a);
            w.last = (a == DEPTH - 1);
            exp_q.push_back(w);
        end
    endtask

    task automatic drain(input int mode, input bit chain_next, input bit chained,
                         input int exp_done, input int exp_first);
        int rel;
        if (!chained) tick();
        load_expected();
        hs_count  = 0;
        first_hs  = -1;
        last_hs   = -1;
        done_rel  = -1;
        run_start = cyc;
        start     = 1'b1;
        out_ready = ready_fn(mode, 0);
        rel = 0;
        while (done_rel < 0 && rel < 400) begin
            tick();
            rel = cyc - run_start;
            start = (mode == 4 && (rel == 4 || rel == 10)) || (chain_next && rel == exp_done);
            out_ready = ready_fn(mode, rel);
            @(negedge clk);
            #1;
            if (rel == 1) begin
                check("busy_after_start", busy, 1);
                check("first_issue_addr", mem_read_addr, 0);
            end
            if (mode == 1 && rel >= 5 && rel <= 9) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, 102);
                check("stall_read_addr", mem_read_addr, 4);
            end
        end
        check("drain_completed", done_rel >= 0, 1);
        check("handshakes", hs_count, DEPTH);
        check("queue_drained", exp_q.size(), 0);
        if (exp_first >= 0) check("first_word_cycle", first_hs, exp_first);
        if (exp_done >= 0) begin
            check("done_cycle", done_rel, exp_done);
            check("last_word_cycle", last_hs, exp_done - 1);
        end
        exp_q.delete();
    endtask

    initial begin
        int dc;
        rst = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        for (int a = 0; a < DEPTH; a++) mem[a] = DATA_W'(100 + a);

        tick();
        tick();
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_addr", out_addr, 0);
        check("rst_read_addr", mem_read_addr, 0);
        tick();
        rst = 1'b0;
        repeat (4) tick();
        check("idle_busy", busy, 0);
        check("idle_read_addr", mem_read_addr, 0);
        check("idle_out_valid", out_valid, 0);

        drain(0, 1'b0, 1'b0, 19, 3);
        drain(1, 1'b0, 1'b0, 24, 3);
        drain(2, 1'b0, 1'b0, 35, 4);
        drain(4, 1'b1, 1'b0, 19, 3);
        drain(0, 1'b0, 1'b1, 19, 3);

        // Reset in cycle 8 of a run.
        tick();
        load_expected();
        hs_count = 0;
        done_rel = -1;
        run_start = cyc;
        start = 1'b1;
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        while (cyc - run_start < 8) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        #1;
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_words", hs_count, 6);
        dc = done_count;
        repeat (25) tick();
        check("rst_mid_no_done", done_count, dc);
        check("rst_mid_idle_valid", out_valid, 0);
        drain(0, 1'b0, 1'b0, 19, 3);

        for (int r = 0; r < 4; r++) begin
            for (int a = 0; a < DEPTH; a++) mem[a] = DATA_W'({$urandom(), $urandom()});
            drain(3, 1'b0, 1'b0, -1, -1);
        end

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
